// File: rtl/riv_fifo_rd_arbiter_if.sv
// Handshake bundle between the read-side arbiter, the FIFO read ports it
// drains, and the downstream valid/ready consumer.
interface riv_fifo_rd_arbiter_if #(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = $clog2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0]            fifo_empty;
    logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_rdata;
    logic [NUM_FIFOS-1:0]            fifo_ren;
    logic                            m_valid;
    logic                            m_ready;
    logic [DATA_WIDTH-1:0]           m_data;
    logic [SRC_WIDTH-1:0]            m_src;
    logic                            m_last;

    // Arbiter side
    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_ren, m_valid, m_data, m_src, m_last
    );

    // FIFO / consumer side
    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_ren, m_valid, m_data, m_src, m_last
    );
endinterface

// File: rtl/riv_fifo_rd_arbiter.sv
// Round-robin read scheduler: grants one non-empty, unmasked FIFO at a time
// for up to MAX_BURST pops and funnels the words into a one-entry output
// register with valid/ready handshake.
module riv_fifo_rd_arbiter #(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [NUM_FIFOS-1:0] fifo_mask,
    riv_fifo_rd_arbiter_if.master bus,
    output logic                 busy
);
    localparam int SW = $clog2(NUM_FIFOS);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [SW-1:0]         grant;
    logic [SW-1:0]         rr_ptr;
    logic [CW-1:0]         burst_cnt;
    logic                  m_valid_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic [SW-1:0]         m_src_r;
    logic                  m_last_r;

    logic                  hit;
    logic [SW-1:0]         pick;
    logic                  pop;
    logic                  last_pop;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_FIFOS-1:0]  ren;

    // Find the first eligible FIFO after rr_ptr, wrapping around
    always_comb begin
        logic [SW-1:0] idx;
        hit  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
            idx = SW'((32'(rr_ptr) + k) % NUM_FIFOS);
            if (!hit && !bus.fifo_empty[idx] && !fifo_mask[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    // Pop qualification, read-data mux and one-hot read-enable decode
    always_comb begin
        pop = (state == BURST) && enable && !fifo_mask[grant] &&
              !bus.fifo_empty[grant] && (!m_valid_r || bus.m_ready);
        last_pop = (burst_cnt == CW'(MAX_BURST - 1));
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            if (grant == SW'(i)) begin
                sel_data = bus.fifo_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ren = '0;
        if (pop) begin
            ren[grant] = 1'b1;
        end
    end

    // Grant FSM, burst counting and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= SW'(NUM_FIFOS - 1);
            burst_cnt <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_src_r   <= '0;
            m_last_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && hit) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    // A pop already implies enable, unmasked and non-empty, so
                    // the else branch covers every non-cap exit reason.
                    if (pop) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        if (last_pop) begin
                            state  <= IDLE;
                            rr_ptr <= grant;
                        end
                    end else if (!enable || fifo_mask[grant] || bus.fifo_empty[grant]) begin
                        state  <= IDLE;
                        rr_ptr <= grant;
                    end
                end
                default: state <= IDLE;
            endcase

            if (pop) begin
                m_valid_r <= 1'b1;
                m_data_r  <= sel_data;
                m_src_r   <= grant;
                m_last_r  <= last_pop;
            end else if (bus.m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign bus.fifo_ren = ren;
    assign bus.m_valid  = m_valid_r;
    assign bus.m_data   = m_data_r;
    assign bus.m_src    = m_src_r;
    assign bus.m_last   = m_last_r;
    assign busy         = (state == BURST);

endmodule

// File: tb/tb_riv_fifo_rd_arbiter.sv
// Bench for riv_fifo_rd_arbiter: FIFO models with per-FIFO expected-word
// queues, a source/last scoreboard, a priority vector table and directed
// multi-cycle sequences. A second instance with MAX_BURST=1 and always
// non-empty FIFOs exercises round-robin fairness in the background.
module tb_riv_fifo_rd_arbiter;
    localparam int NF = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    logic enable;
    logic [NF-1:0] fifo_mask;
    logic busy;
    logic busy2;

    always #5 clk = ~clk;

    riv_fifo_rd_arbiter_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) bus ();
    riv_fifo_rd_arbiter_if #(.NUM_FIFOS(NF), .DATA_WIDTH(DW)) bus2 ();

    riv_fifo_rd_arbiter #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fifo_mask (fifo_mask),
        .bus       (bus),
        .busy      (busy)
    );

    riv_fifo_rd_arbiter #(.NUM_FIFOS(NF), .DATA_WIDTH(DW), .MAX_BURST(1)) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .enable    (1'b1),
        .fifo_mask ('0),
        .bus       (bus2),
        .busy      (busy2)
    );

    // FIFO models for the main instance
    logic [DW-1:0] mem [NF][256];
    logic [7:0]    rd_ptr [NF] = '{default: '0};
    logic [7:0]    wr_ptr [NF];

    always @(posedge clk) begin
        for (int i = 0; i < NF; i++) begin
            if (bus.fifo_ren[i]) rd_ptr[i] <= rd_ptr[i] + 8'd1;
        end
    end

    always_comb begin
        bus.fifo_empty = '0;
        bus.fifo_rdata = '0;
        for (int i = 0; i < NF; i++) begin
            bus.fifo_empty[i]            = (rd_ptr[i] == wr_ptr[i]);
            bus.fifo_rdata[i*DW +: DW]   = mem[i][rd_ptr[i]];
        end
    end

    assign bus2.fifo_empty = '0;
    assign bus2.fifo_rdata = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    assign bus2.m_ready    = 1'b1;

    // Scoreboard state
    typedef struct packed {
        logic [1:0] src;
        logic       last;
    } sl_t;

    logic [DW-1:0] exp_q [NF][$];
    sl_t           exp_sl [$];
    sl_t           mon_e;
    int            pop_cyc [$];
    int            checks   = 0;
    int            errors   = 0;
    int            accepted = 0;
    int            cyc      = 0;
    int            seq      = 0;
    int            exp_src2 = 0;
    int            seen2    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Main-instance monitor: one-hot read enables and accepted-word scoreboard
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(bus.fifo_ren)) else begin
            errors++;
            $display("FAIL ren_onehot: got %b expected one-hot or zero", bus.fifo_ren);
        end
        if (|bus.fifo_ren) pop_cyc.push_back(cyc);
        if (rst_n && bus.m_valid && bus.m_ready) begin
            accepted++;
            if (exp_q[bus.m_src].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got word %0h from src %0d expected none", bus.m_data, bus.m_src);
            end else begin
                chk("sb_data", bus.m_data, exp_q[bus.m_src].pop_front());
            end
            if (exp_sl.size() > 0) begin
                mon_e = exp_sl.pop_front();
                chk("sb_src", bus.m_src, mon_e.src);
                chk("sb_last", bus.m_last, mon_e.last);
            end
        end
    end

    // Fairness monitor on the MAX_BURST=1 instance
    always @(negedge clk) begin
        if (rst2_n) begin
            checks++;
            assert ($onehot0(bus2.fifo_ren)) else begin
                errors++;
                $display("FAIL rr_onehot: got %b expected one-hot or zero", bus2.fifo_ren);
            end
            if (bus2.m_valid && seen2 < 16) begin
                seen2++;
                chk("rr_src", bus2.m_src, exp_src2);
                chk("rr_last", bus2.m_last, 1);
                chk("rr_data", bus2.m_data, 32'hC0DE_0000 + exp_src2);
                exp_src2 = (exp_src2 + 1) % NF;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int f, input int n);
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] w;
            w = 32'hA000_0000 + 32'(f << 24) + 32'(seq);
            mem[f][wr_ptr[f]] = w;
            wr_ptr[f] = wr_ptr[f] + 8'd1;
            exp_q[f].push_back(w);
            seq++;
        end
    endtask

    task automatic push_sl(input int src, input int n, input logic last_at_end);
        for (int k = 0; k < n; k++) begin
            exp_sl.push_back('{src: 2'(src), last: (k == n - 1) ? last_at_end : 1'b0});
        end
    endtask

    task automatic drain(input string name);
        int n;
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        fifo_mask   = '0;
        n = 0;
        while (n < 200 && !((&bus.fifo_empty) && !bus.m_valid && !busy)) begin
            step();
            n++;
        end
        chk({name, "_timeout"}, (n < 200), 1);
        step();
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("%s_left%0d", name, i), exp_q[i].size(), 0);
        end
        chk({name, "_seq_left"}, exp_sl.size(), 0);
    endtask

    typedef struct {
        logic          en;
        logic [NF-1:0] mask;
        logic [NF-1:0] ne;
        logic [NF-1:0] exp_ren;
    } vec_t;

    initial begin
        vec_t vt [8];
        int   base;

        vt[0] = '{1'b1, 4'b0000, 4'b0001, 4'b0001};
        vt[1] = '{1'b1, 4'b0000, 4'b1110, 4'b0010};
        vt[2] = '{1'b1, 4'b0000, 4'b1000, 4'b1000};
        vt[3] = '{1'b1, 4'b0001, 4'b0011, 4'b0010};
        vt[4] = '{1'b0, 4'b0000, 4'b1111, 4'b0000};
        vt[5] = '{1'b1, 4'b1111, 4'b1111, 4'b0000};
        vt[6] = '{1'b1, 4'b0000, 4'b0000, 4'b0000};
        vt[7] = '{1'b1, 4'b0101, 4'b1100, 4'b1000};

        for (int i = 0; i < NF; i++) wr_ptr[i] = '0;
        bus.m_ready = 1'b0;
        enable      = 1'b0;
        fifo_mask   = '0;
        rst_n       = 1'b1;
        rst2_n      = 1'b1;
        #1;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_src", bus.m_src, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ren", bus.fifo_ren, 0);
        rst2_n = 1'b1;

        // Priority from reset: first eligible FIFO scanning from 0
        for (int v = 0; v < 8; v++) begin
            rst_n = 1'b0;
            step();
            for (int i = 0; i < NF; i++) if (vt[v].ne[i]) load(i, 1);
            enable      = vt[v].en;
            fifo_mask   = vt[v].mask;
            bus.m_ready = 1'b1;
            step();
            rst_n = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d_idle_ren", v), bus.fifo_ren, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_ren", v), bus.fifo_ren, vt[v].exp_ren);
            chk($sformatf("vec%0d_busy", v), busy, (vt[v].exp_ren != 0));
            step();
            drain($sformatf("vec%0d", v));
        end

        // Burst cap with two competing FIFOs
        rst_n = 1'b0;
        step();
        load(0, 10);
        load(1, 10);
        push_sl(0, 4, 1'b1);
        push_sl(1, 4, 1'b1);
        push_sl(0, 4, 1'b1);
        push_sl(1, 4, 1'b1);
        push_sl(0, 2, 1'b0);
        push_sl(1, 2, 1'b0);
        pop_cyc.delete();
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        drain("cap");
        chk("cap_pops", pop_cyc.size(), 20);
        if (pop_cyc.size() >= 17) begin
            chk("cap_span", pop_cyc[15] - pop_cyc[0], 18);
            chk("cap_gap", pop_cyc[16] - pop_cyc[15], 2);
        end

        // Backpressure mid-burst
        rst_n = 1'b0;
        step();
        load(2, 4);
        push_sl(2, 4, 1'b1);
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        base = accepted;
        repeat (3) @(negedge clk);
        step();
        bus.m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ren", bus.fifo_ren, 0);
            chk("bp_valid", bus.m_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_data", bus.m_data, exp_q[2][0]);
            chk("bp_src", bus.m_src, 2);
        end
        step();
        drain("bp");
        chk("bp_count", accepted - base, 4);

        // Mask mid-burst with a held word, then global enable low
        rst_n = 1'b0;
        step();
        load(0, 4);
        load(1, 2);
        push_sl(0, 2, 1'b0);
        push_sl(1, 2, 1'b0);
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        step();
        fifo_mask   = 4'b0001;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mk_ren_stall", bus.fifo_ren, 0);
            chk("mk_valid", bus.m_valid, 1);
            chk("mk_data", bus.m_data, exp_q[0][0]);
        end
        step();
        bus.m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mk_ren0", bus.fifo_ren[0], 0);
        end
        chk("mk_left0", wr_ptr[0] - rd_ptr[0], 2);
        chk("mk_empty1", bus.fifo_empty[1], 1);
        chk("mk_seq_done", exp_sl.size(), 0);
        step();
        enable    = 1'b0;
        fifo_mask = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("en_ren", bus.fifo_ren, 0);
        end
        step();
        drain("mk");

        // Reset while a word is held in the output register
        rst_n = 1'b0;
        step();
        load(1, 4);
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        step();
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("rs_valid_pre", bus.m_valid, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rs_valid", bus.m_valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ren", bus.fifo_ren, 0);
        chk("rs_data", bus.m_data, 0);
        void'(exp_q[1].pop_front());
        load(0, 1);
        bus.m_ready = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_idle_ren", bus.fifo_ren, 0);
        @(negedge clk);
        chk("rs_restart", bus.fifo_ren, 4'b0001);
        step();
        drain("rs");

        // Background fairness instance
        for (int k = 0; k < 100 && seen2 < 16; k++) step();
        chk("rr_done", seen2, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
